// File: rtl/wvb_rdout_dpram_writer_pkg.sv
// Shared definitions for the direct-readout DPRAM writer and xdom's DPRAM instance.
package wvb_rdout_pkg;

   localparam int DPRAM_ADDR_W    = 10;
   localparam int DPRAM_MAX_WORDS = 2 * (2 ** DPRAM_ADDR_W);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAP,
      FLUSH,
      RUN,
      WAIT_BUSY,
      WAIT_DONE
   } wvb_rdout_state_e;

endpackage

// File: rtl/wvb_rdout_dpram_writer_packer.sv
// Packs 16-bit waveform words into 32-bit DPRAM writes, earlier word in bits[15:0].
module wvb_word_packer
   import wvb_rdout_pkg::*;
#(
   parameter int ADDR_W = DPRAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [15:0]       data,
   input  logic              flush,
   output logic              wren,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data
);

   logic              phase;
   logic [15:0]       pending_lo;
   logic [ADDR_W-1:0] addr_next;

   // Write port is registered: a pair completed in CAP is written on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= 1'b0;
         pending_lo <= '0;
         addr_next  <= '0;
         wren       <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         wren <= 1'b0;
         if (clear) begin
            phase      <= 1'b0;
            pending_lo <= '0;
            addr_next  <= '0;
         end else if (accept) begin
            if (!phase) begin
               pending_lo <= data;
               phase      <= 1'b1;
            end else begin
               wren      <= 1'b1;
               wr_addr   <= addr_next;
               wr_data   <= {data, pending_lo};
               addr_next <= addr_next + 1'b1;
               phase     <= 1'b0;
            end
         end else if (flush && phase) begin
            // Odd word count: the lone final word is zero-padded in the high half.
            wren      <= 1'b1;
            wr_addr   <= addr_next;
            wr_data   <= {16'h0000, pending_lo};
            addr_next <= addr_next + 1'b1;
            phase     <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/wvb_rdout_dpram_writer.sv
// Writer side of the direct-readout DPRAM handshake: waveform buffer -> DPRAM -> xdom reader.
module wvb_rdout_dpram_writer
   import wvb_rdout_pkg::*;
#(
   parameter int ADDR_W    = DPRAM_ADDR_W,
   parameter int MAX_WORDS = DPRAM_MAX_WORDS,
   parameter int LEN_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              dpram_mode,
   input  logic              wvb_empty,
   output logic              wvb_rd_req,
   input  logic [15:0]       wvb_data,
   input  logic              wvb_last,
   output logic              rdout_dpram_wren,
   output logic [ADDR_W-1:0] rdout_dpram_wr_addr,
   output logic [31:0]       rdout_dpram_data,
   output logic              rdout_dpram_run,
   output logic [LEN_W-1:0]  dpram_len,
   input  logic              dpram_busy,
   output logic              truncated,
   output logic [LEN_W-1:0]  wfm_count,
   output logic              idle,
   output wvb_rdout_state_e  state_dbg
);

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_WORDS);

   wvb_rdout_state_e state, state_nxt;
   logic [LEN_W-1:0] word_cnt;
   logic             start;
   logic             cap_keep;
   logic             flush;

   // Handshakes: wvb_rd_req is a single-cycle strobe issued only while !wvb_empty, data returns
   // the next cycle; rdout_dpram_run is a single-cycle strobe, after which the DPRAM belongs to
   // xdom until dpram_busy has been seen high and then low again.
   always_comb begin
      state_nxt       = state;
      wvb_rd_req      = 1'b0;
      rdout_dpram_run = 1'b0;
      start           = 1'b0;
      cap_keep        = 1'b0;
      flush           = 1'b0;
      case (state)
         IDLE: begin
            if (enable && dpram_mode && !wvb_empty && !dpram_busy) begin
               start     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (!wvb_empty) begin
               wvb_rd_req = 1'b1;
               state_nxt  = CAP;
            end
         end
         CAP: begin
            cap_keep  = (word_cnt < MAX_CNT);
            state_nxt = wvb_last ? FLUSH : REQ;
         end
         FLUSH: begin
            flush     = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            rdout_dpram_run = 1'b1;
            state_nxt       = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (dpram_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!dpram_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt  <= '0;
         truncated <= 1'b0;
         dpram_len <= '0;
         wfm_count <= '0;
      end else begin
         if (start) begin
            word_cnt  <= '0;
            truncated <= 1'b0;
         end
         if (state == CAP) begin
            if (cap_keep) word_cnt  <= word_cnt + 1'b1;
            else          truncated <= 1'b1;
         end
         if (flush) dpram_len <= word_cnt;
         if (rdout_dpram_run) wfm_count <= wfm_count + 1'b1;
      end
   end

   wvb_word_packer #(
      .ADDR_W (ADDR_W)
   ) u_packer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start),
      .accept  (cap_keep),
      .data    (wvb_data),
      .flush   (flush),
      .wren    (rdout_dpram_wren),
      .wr_addr (rdout_dpram_wr_addr),
      .wr_data (rdout_dpram_data)
   );

   assign idle      = (state == IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_wvb_rdout_dpram_writer.sv
// Directed bench for wvb_rdout_dpram_writer with a write/run scoreboard and a FIFO responder.
module tb_wvb_rdout_dpram_writer;
   import wvb_rdout_pkg::*;

   localparam int ADDR_W = 10;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              dpram_mode = 1'b0;
   logic              dpram_busy = 1'b0;
   logic              wvb_empty;
   logic              wvb_rd_req;
   logic [15:0]       wvb_data = 16'h0;
   logic              wvb_last = 1'b0;
   logic              rdout_dpram_wren;
   logic [ADDR_W-1:0] rdout_dpram_wr_addr;
   logic [31:0]       rdout_dpram_data;
   logic              rdout_dpram_run;
   logic [LEN_W-1:0]  dpram_len;
   logic              truncated;
   logic [LEN_W-1:0]  wfm_count;
   logic              idle;
   wvb_rdout_state_e  state_dbg;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem_d [0:8191];
   logic        mem_l [0:8191];
   int          pushed = 0;
   int          popped = 0;
   int          rd_cnt = 0;

   logic [ADDR_W+31:0] exp_q [$];
   logic [LEN_W:0]     run_q [$];

   wvb_rdout_dpram_writer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .enable              (enable),
      .dpram_mode          (dpram_mode),
      .wvb_empty           (wvb_empty),
      .wvb_rd_req          (wvb_rd_req),
      .wvb_data            (wvb_data),
      .wvb_last            (wvb_last),
      .rdout_dpram_wren    (rdout_dpram_wren),
      .rdout_dpram_wr_addr (rdout_dpram_wr_addr),
      .rdout_dpram_data    (rdout_dpram_data),
      .rdout_dpram_run     (rdout_dpram_run),
      .dpram_len           (dpram_len),
      .dpram_busy          (dpram_busy),
      .truncated           (truncated),
      .wfm_count           (wfm_count),
      .idle                (idle),
      .state_dbg           (state_dbg)
   );

   // clock / FIFO responder
   always #5 clk = ~clk;

   assign wvb_empty = (pushed == popped);

   always @(posedge clk) begin
      if (wvb_rd_req) begin
         wvb_data <= mem_d[popped];
         wvb_last <= mem_l[popped];
         popped   <= popped + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic push_word(input logic [15:0] d, input logic l);
      mem_d[pushed] = d;
      mem_l[pushed] = l;
      pushed++;
   endtask

   task automatic exp_wr(input int a, input logic [31:0] d);
      exp_q.push_back({ADDR_W'(a), d});
   endtask

   task automatic exp_run(input logic t, input int len);
      run_q.push_back({t, LEN_W'(len)});
   endtask

   task automatic handshake(input int hold, output int rd_in_busy);
      int n;
      int snap;
      n = 0;
      rd_in_busy = 0;
      while (!rdout_dpram_run && n < 10000) begin
         @(negedge clk);
         n++;
      end
      if (!rdout_dpram_run) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: got no run strobe within %0d cycles", n);
         return;
      end
      snap = rd_cnt;
      @(negedge clk);
      dpram_busy = 1'b1;
      repeat (hold) @(negedge clk);
      rd_in_busy = rd_cnt - snap;
      dpram_busy = 1'b0;
      n = 0;
      while (!idle && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_after_busy", {63'h0, idle}, 64'h1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [ADDR_W+31:0] e;
      logic [LEN_W:0]     r;
      if (rst_n && wvb_rd_req) rd_cnt++;
      if (rst_n && rdout_dpram_wren) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dpram_write: got addr 0x%0h data 0x%0h expected no write",
                     rdout_dpram_wr_addr, rdout_dpram_data);
         end else begin
            e = exp_q.pop_front();
            chk("dpram_write", {22'h0, rdout_dpram_wr_addr, rdout_dpram_data}, {22'h0, e});
         end
      end
      if (rst_n && rdout_dpram_run) begin
         if (run_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL run_strobe: got len 0x%0h expected no run", dpram_len);
         end else begin
            r = run_q.pop_front();
            chk("run_len_trunc", {47'h0, truncated, dpram_len}, {47'h0, r});
         end
      end
   end

   initial begin
      int base;
      int blocked;
      int n;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_idle", {63'h0, idle}, 64'h1);
      chk("rst_wren", {63'h0, rdout_dpram_wren}, 64'h0);
      chk("rst_addr_data", {22'h0, rdout_dpram_wr_addr, rdout_dpram_data}, 64'h0);
      chk("rst_run", {63'h0, rdout_dpram_run}, 64'h0);
      chk("rst_len_cnt", {32'h0, dpram_len, wfm_count}, 64'h0);
      chk("rst_trunc_rdreq", {62'h0, truncated, wvb_rd_req}, 64'h0);
      rst_n      = 1'b1;
      enable     = 1'b1;
      dpram_mode = 1'b1;
      @(negedge clk);

      // 4-word waveform
      exp_wr(0, 32'h2222_1111);
      exp_wr(1, 32'h4444_3333);
      exp_run(1'b0, 4);
      push_word(16'h1111, 1'b0);
      push_word(16'h2222, 1'b0);
      push_word(16'h3333, 1'b0);
      push_word(16'h4444, 1'b1);
      handshake(3, blocked);
      chk("wfm_count_1", 64'(wfm_count), 64'd1);

      // 3-word waveform, zero pad
      exp_wr(0, 32'hBBBB_AAAA);
      exp_wr(1, 32'h0000_CCCC);
      exp_run(1'b0, 3);
      push_word(16'hAAAA, 1'b0);
      push_word(16'hBBBB, 1'b0);
      push_word(16'hCCCC, 1'b1);
      handshake(2, blocked);
      chk("wfm_count_2", 64'(wfm_count), 64'd2);

      // 2050-word waveform: last two words discarded
      base = rd_cnt;
      for (int k = 0; k < 1024; k++) exp_wr(k, {16'(2 * k + 1), 16'(2 * k)});
      exp_run(1'b1, 2048);
      for (int i = 0; i < 2050; i++) push_word(16'(i), (i == 2049));
      handshake(2, blocked);
      chk("long_rd_pulses", 64'(rd_cnt - base), 64'd2050);
      chk("long_fifo_drained", 64'(pushed - popped), 64'd0);
      chk("wfm_count_3", 64'(wfm_count), 64'd3);

      // two queued waveforms, busy held 100 cycles
      exp_wr(0, 32'h0202_0101);
      exp_run(1'b0, 2);
      exp_wr(0, 32'h0000_0303);
      exp_run(1'b0, 1);
      push_word(16'h0101, 1'b0);
      push_word(16'h0202, 1'b1);
      push_word(16'h0303, 1'b1);
      handshake(100, blocked);
      chk("no_rd_while_busy", 64'(blocked), 64'd0);
      handshake(2, blocked);
      chk("wfm_count_5", 64'(wfm_count), 64'd5);

      // enable dropped mid-waveform
      base = rd_cnt;
      exp_wr(0, 32'h1001_1000);
      exp_wr(1, 32'h1003_1002);
      exp_wr(2, 32'h1005_1004);
      exp_run(1'b0, 6);
      for (int i = 0; i < 6; i++) push_word(16'h1000 + 16'(i), (i == 5));
      n = 0;
      while (rd_cnt < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      enable = 1'b0;
      handshake(2, blocked);
      chk("wfm_count_6", 64'(wfm_count), 64'd6);
      base = rd_cnt;
      push_word(16'h5A5A, 1'b1);
      repeat (20) @(negedge clk);
      chk("disabled_stays_idle", {63'h0, idle}, 64'h1);
      chk("disabled_no_rd", 64'(rd_cnt - base), 64'd0);
      exp_wr(0, 32'h0000_5A5A);
      exp_run(1'b0, 1);
      enable = 1'b1;
      handshake(2, blocked);
      chk("wfm_count_7", 64'(wfm_count), 64'd7);

      // asynchronous reset during CAP
      push_word(16'h9999, 1'b0);
      push_word(16'hEEEE, 1'b1);
      n = 0;
      while (!(state_dbg == CAP && popped == pushed) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached_cap", {63'h0, (state_dbg == CAP)}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_idle", {63'h0, idle}, 64'h1);
      chk("async_len_cnt", {32'h0, dpram_len, wfm_count}, 64'h0);
      chk("async_strobes", {61'h0, wvb_rd_req, rdout_dpram_wren, rdout_dpram_run}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_wr(0, 32'h8888_7777);
      exp_run(1'b0, 2);
      push_word(16'h7777, 1'b0);
      push_word(16'h8888, 1'b1);
      handshake(2, blocked);
      chk("wfm_count_after_rst", 64'(wfm_count), 64'd1);

      // report
      repeat (5) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("run_q_drained", 64'(run_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wvb_rdout_dpram_writer.md
Name: wvb_rdout_dpram_writer

Overview:
- Writer side of the direct-readout DPRAM handshake.
- Pulls one waveform at a time from the waveform buffer read port and packs its 16-bit words into 32-bit DPRAM writes starting at address 0.
- At waveform end, pulses rdout_dpram_run with the word count, then holds off until the xdom register-side reader raises and drops dpram_busy.
- Sits between the waveform buffer and the xdom block, and is gated by xdom's wvb_reader_enable and wvb_reader_dpram_mode.

Parameters:
- ADDR_W, 10, DPRAM write address width (32-bit words).
- MAX_WORDS, 2048, maximum 16-bit words stored per waveform; must equal 2*2**ADDR_W.
- LEN_W, 16, width of dpram_len and wfm_count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- enable  in  1  wvb_reader_enable; level, allows a new waveform to start.
- dpram_mode  in  1  wvb_reader_dpram_mode; must be 1 to start a waveform.
- wvb_empty  in  1  waveform buffer read port empty.
- wvb_rd_req  out  1  one-cycle read strobe; data is returned exactly 1 cycle later.
- wvb_data  in  16  read data, valid the cycle after wvb_rd_req.
- wvb_last  in  1  qualifies wvb_data as the final word of the waveform.
- rdout_dpram_wren  out  1  DPRAM write enable.
- rdout_dpram_wr_addr  out  ADDR_W  DPRAM write address.
- rdout_dpram_data  out  32  DPRAM write data.
- rdout_dpram_run  out  1  one-cycle strobe: DPRAM holds a complete waveform.
- dpram_len  out  LEN_W  number of valid 16-bit words; stable from the run strobe until the next waveform starts.
- dpram_busy  in  1  xdom reader owns the DPRAM.
- truncated  out  1  last waveform exceeded MAX_WORDS.
- wfm_count  out  LEN_W  waveforms handed off; wraps at 2**LEN_W.
- idle  out  1  FSM is in IDLE.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, except idle=1. FSM goes to IDLE; pending half-word and counters are cleared. Reset mid-operation abandons the waveform; DPRAM contents are don't-care.
- IDLE: when enable && dpram_mode && !wvb_empty && !dpram_busy, go to REQ and clear word_cnt, wr_addr, truncated and pending.
- REQ: if !wvb_empty, assert wvb_rd_req for 1 cycle and go to CAP; otherwise stay in REQ.
- CAP: capture wvb_data and wvb_last, then act on word_cnt:
  - word_cnt < MAX_WORDS and even: store the word in low half-word pending_lo; word_cnt+1.
  - word_cnt < MAX_WORDS and odd: write {wvb_data, pending_lo} at wr_addr; wr_addr+1; word_cnt+1.
  - word_cnt == MAX_WORDS: discard the word and set truncated=1.
- CAP exit: if wvb_last=1, go to FLUSH; otherwise go to REQ.
- Throughput: 1 word per 2 clocks. No read is issued after the last word is seen.
- FLUSH: if word_cnt is odd, write {16'h0000, pending_lo} at wr_addr. Go to RUN.
- RUN: rdout_dpram_run=1 for exactly 1 cycle, with dpram_len=word_cnt (at most MAX_WORDS). wfm_count+1. Go to WAIT_BUSY.
- WAIT_BUSY: wait for dpram_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for dpram_busy=0, then go to IDLE.
- Half-word order: the earlier word goes in bits[15:0], so 16-bit read address 2n returns word 2n.
- Enable or dpram_mode dropping mid-waveform: the current waveform completes the full handshake. They are sampled only in IDLE.
- A zero-length waveform cannot occur, because wvb_last always accompanies a read word.
- wr_addr never wraps: at most MAX_WORDS/2 writes occur per waveform.
- dpram_busy already high in IDLE blocks the start.

Decomposition:
- Shared package wvb_rdout_pkg holds:
  - FSM state enum: IDLE, REQ, CAP, FLUSH, RUN, WAIT_BUSY, WAIT_DONE.
  - Localparams DPRAM_ADDR_W and DPRAM_MAX_WORDS, shared with xdom's DPRAM instance.
- One natural sub-module, wvb_word_packer, owns pending_lo, the odd/even toggle, wr_addr and the flush/zero-pad logic. The FSM and handshake stay in the top level.

Test Plan:
- 4-word waveform 0x1111, 0x2222, 0x3333, 0x4444 (last on 0x4444) -> writes addr0=0x22221111 and addr1=0x44443333; run pulse with dpram_len=4; wfm_count=1; after busy rises then falls, idle=1.
- 3-word waveform 0xAAAA, 0xBBBB, 0xCCCC -> writes addr0=0xBBBBAAAA and addr1=0x0000CCCC; dpram_len=3; truncated=0.
- 2050-word waveform -> exactly 1024 writes, the last at addr 0x3FF; 2050 rd_req pulses with the FIFO drained through last; dpram_len=2048; truncated=1.
- Two waveforms queued, busy held high 100 cycles after the first run -> wvb_rd_req stays 0 until busy falls. The second waveform then writes from addr0; wfm_count=2.
- enable dropped after the 2nd word of a 6-word waveform -> all 3 writes occur and run pulses with len=6; no new start while enable=0.
- rst_n asserted asynchronously in CAP -> all outputs 0 and idle=1 without waiting for a clock edge. After release with enable=1, the next waveform starts at addr0.
